// File: rtl/outbuf_pingpong_sram.sv
// outbuf_pingpong_sram
//   Double-buffered (ping-pong) output frame buffer on two SRAM banks.
//   The CNN writer fills bank wBank while the display reader drains bank rBank.
//   A bank's full bit is set by the writer's frame-done handshake and cleared
//   by the reader's, so a frame is never read while it is being written.
//
//   Optional feature macro: OUTBUF_RGB888_EN
//     undefined : oData = raw DATA_W word, read latency 1
//     defined   : oData = RGB565 expanded to RGB888 (DATA_W must be 16),
//                 one extra output stage, read latency 2
//
// Ports
//   iClk, iRsn                    clock, async active-low reset
//   iWrEn/iWrAddr/iData           writer pixel strobe, address, data
//   iWrFrameDone                  writer finished its bank (1-cycle pulse)
//   iRdEn/iRdAddr                 reader pixel strobe, address
//   iRdFrameDone                  reader finished its bank (1-cycle pulse)
//   oWrReady                      writer bank is free
//   oRdReady                      reader bank holds a complete frame
//   oData/oRdValid                read pixel and its valid strobe
//   oDropCnt                      saturating count of writes refused (bank full)
module outbuf_pingpong_sram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 130560,
  parameter int ADDR_W = 17,
  parameter int DROP_W = 8,
`ifdef OUTBUF_RGB888_EN
  localparam int OUT_W = 24
`else
  localparam int OUT_W = DATA_W
`endif
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iData,
  input  logic              iWrFrameDone,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iRdAddr,
  input  logic              iRdFrameDone,
  output logic              oWrReady,
  output logic              oRdReady,
  output logic [OUT_W-1:0]  oData,
  output logic              oRdValid,
  output logic [DROP_W-1:0] oDropCnt
);

  // DEPTH may equal 2**ADDR_W, so compare with one extra bit.
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  // full_q encodes the bank FSM: 00 both empty, one bit set one full, 11 both full.
  logic [1:0]        full_q, full_d;
  logic              wbank_q, rbank_q;
  logic [DROP_W-1:0] drop_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvld_q;
  logic [DATA_W-1:0] rd_word;

  logic wr_in_rng, rd_in_rng, wr_fire, rd_fire, wr_done, rd_done;

  assign oWrReady  = ~full_q[wbank_q];
  assign oRdReady  = full_q[rbank_q];
  assign wr_in_rng = {1'b0, iWrAddr} < DEPTH_C;
  assign rd_in_rng = {1'b0, iRdAddr} < DEPTH_C;
  assign wr_fire   = iWrEn & oWrReady & wr_in_rng;
  assign rd_fire   = iRdEn & oRdReady;
  assign wr_done   = iWrFrameDone & oWrReady;
  assign rd_done   = iRdFrameDone & oRdReady;

  // Simultaneous done pulses always hit different banks (one empty, one full).
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wbank_q] = 1'b1;
    if (rd_done) full_d[rbank_q] = 1'b0;
  end

  // SRAM arrays: no reset on contents.
  always_ff @(posedge iClk) begin
    if (wr_fire) begin
      if (wbank_q) mem1[iWrAddr] <= iData;
      else         mem0[iWrAddr] <= iData;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_rng) rd_word = rbank_q ? mem1[iRdAddr] : mem0[iRdAddr];
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      drop_q  <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_done) wbank_q <= ~wbank_q;
      if (rd_done) rbank_q <= ~rbank_q;
      if (iWrEn && !oWrReady && drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + 1'b1;
      // rd_word uses the pre-swap rBank, so a read alongside rd-done sees the old bank.
      if (rd_fire) rdata_q <= rd_word;
      rvld_q <= rd_fire;
    end
  end

  assign oDropCnt = drop_q;

`ifdef OUTBUF_RGB888_EN
  logic [23:0] rgb_q;
  logic        rgb_vld_q;

  // Replicate MSBs into the low bits so full-scale 5/6-bit maps to 0xFF.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      rgb_q     <= '0;
      rgb_vld_q <= 1'b0;
    end else begin
      if (rvld_q)
        rgb_q <= {rdata_q[15:11], rdata_q[15:13],
                  rdata_q[10:5],  rdata_q[10:9],
                  rdata_q[4:0],   rdata_q[4:2]};
      rgb_vld_q <= rvld_q;
    end
  end

  assign oData    = rgb_q;
  assign oRdValid = rgb_vld_q;
`else
  assign oData    = rdata_q;
  assign oRdValid = rvld_q;
`endif

endmodule

// File: tb/tb_outbuf_pingpong_sram.sv
module tb_outbuf_pingpong_sram;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;
  localparam int DROP_W = 8;
`ifdef OUTBUF_RGB888_EN
  localparam int OUT_W = 24;
  localparam int LAT   = 2;
`else
  localparam int OUT_W = DATA_W;
  localparam int LAT   = 1;
`endif

  logic              iClk = 1'b0;
  logic              iRsn;
  logic              iWrEn, iWrFrameDone, iRdEn, iRdFrameDone;
  logic [ADDR_W-1:0] iWrAddr, iRdAddr;
  logic [DATA_W-1:0] iData;
  logic              oWrReady, oRdReady, oRdValid;
  logic [OUT_W-1:0]  oData;
  logic [DROP_W-1:0] oDropCnt;

  int ntests = 0;
  int nfail  = 0;

  outbuf_pingpong_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
    .iClk(iClk), .iRsn(iRsn),
    .iWrEn(iWrEn), .iWrAddr(iWrAddr), .iData(iData), .iWrFrameDone(iWrFrameDone),
    .iRdEn(iRdEn), .iRdAddr(iRdAddr), .iRdFrameDone(iRdFrameDone),
    .oWrReady(oWrReady), .oRdReady(oRdReady), .oData(oData),
    .oRdValid(oRdValid), .oDropCnt(oDropCnt)
  );

  always #5 iClk = ~iClk;

  // Expected output word for a stored pixel.
  function automatic logic [OUT_W-1:0] expo(input logic [15:0] d);
`ifdef OUTBUF_RGB888_EN
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    iWrEn = 1'b1; iWrAddr = a; iData = d;
    tick();
    iWrEn = 1'b0;
  endtask

  task automatic wr_done();
    iWrFrameDone = 1'b1; tick(); iWrFrameDone = 1'b0;
  endtask

  task automatic rd_done();
    iRdFrameDone = 1'b1; tick(); iRdFrameDone = 1'b0;
  endtask

  // Issue one read and wait out the pipeline latency.
  task automatic rd(input logic [ADDR_W-1:0] a);
    iRdEn = 1'b1; iRdAddr = a;
    tick();
    iRdEn = 1'b0;
    repeat (LAT-1) tick();
  endtask

  logic [15:0] px [4];

  initial begin
    px[0] = 16'hF800; px[1] = 16'h07E0; px[2] = 16'h001F; px[3] = 16'hFFFF;
    iRsn = 1'b0; iWrEn = 1'b0; iWrFrameDone = 1'b0; iRdEn = 1'b0; iRdFrameDone = 1'b0;
    iWrAddr = '0; iRdAddr = '0; iData = '0;
    repeat (2) tick();

    check("rst_wr_ready", 32'(oWrReady), 32'd1);
    check("rst_rd_ready", 32'(oRdReady), 32'd0);
    check("rst_data",     32'(oData),    32'd0);
    check("rst_valid",    32'(oRdValid), 32'd0);
    check("rst_drop",     32'(oDropCnt), 32'd0);
    iRsn = 1'b1;
    tick();

    // Fill bank0 with four pixels and hand it to the reader.
    for (int i = 0; i < 4; i++) wr(ADDR_W'(i), px[i]);
    wr_done();
    check("t1_rd_ready", 32'(oRdReady), 32'd1);
    check("t1_wr_ready", 32'(oWrReady), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(ADDR_W'(i));
      check($sformatf("t1_rd%0d_data", i), 32'(oData), 32'(expo(px[i])));
      check($sformatf("t1_rd%0d_vld", i),  32'(oRdValid), 32'd1);
    end
    tick();
    check("t1_idle_vld",  32'(oRdValid), 32'd0);
    check("t1_idle_hold", 32'(oData),    32'(expo(16'hFFFF)));
`ifdef OUTBUF_RGB888_EN
    rd(4'd0);
    check("t6_red",   32'(oData), 32'h00FF0000);
    rd(4'd1);
    check("t6_green", 32'(oData), 32'h0000FF00);
`endif

    // Fill bank1 too; writer now has no free bank.
    for (int i = 0; i < 4; i++) wr(ADDR_W'(i), 16'h1110 + 16'(i));
    wr_done();
    check("t2_wr_ready", 32'(oWrReady), 32'd0);
    check("t2_rd_ready", 32'(oRdReady), 32'd1);
    for (int i = 0; i < 3; i++) wr(4'd0, 16'hDEAD);
    check("t2_drop3", 32'(oDropCnt), 32'd3);
    rd(4'd0);
    check("t2_bank0_kept", 32'(oData), 32'(expo(16'hF800)));

    // Drop counter saturation.
    iWrEn = 1'b1; iWrAddr = 4'd2;
    repeat (300) tick();
    iWrEn = 1'b0;
    check("t3_drop_sat", 32'(oDropCnt), 32'd255);

    // Release bank0: reader moves to bank1, writer gets bank0.
    rd_done();
    check("t4a_rd_ready", 32'(oRdReady), 32'd1);
    check("t4a_wr_ready", 32'(oWrReady), 32'd1);
    rd(4'd0);
    check("t4a_bank1", 32'(oData), 32'(expo(16'h1110)));

    // Simultaneous done pulses in ONE_FULL.
    wr(4'd0, 16'h1234);
    iWrFrameDone = 1'b1; iRdFrameDone = 1'b1;
    tick();
    iWrFrameDone = 1'b0; iRdFrameDone = 1'b0;
    check("t4b_rd_ready", 32'(oRdReady), 32'd1);
    check("t4b_wr_ready", 32'(oWrReady), 32'd1);
    rd(4'd0);
    check("t4b_bank0", 32'(oData), 32'(expo(16'h1234)));

    // Again, with a read in the swap cycle: it must come from the old bank.
    wr(4'd1, 16'hABCD);
    iWrFrameDone = 1'b1; iRdFrameDone = 1'b1; iRdEn = 1'b1; iRdAddr = 4'd0;
    tick();
    iWrFrameDone = 1'b0; iRdFrameDone = 1'b0; iRdEn = 1'b0;
    repeat (LAT-1) tick();
    check("t4c_oldbank_data", 32'(oData),    32'(expo(16'h1234)));
    check("t4c_oldbank_vld",  32'(oRdValid), 32'd1);
    check("t4c_rd_ready",     32'(oRdReady), 32'd1);
    check("t4c_wr_ready",     32'(oWrReady), 32'd1);
    rd(4'd1);
    check("t4c_bank1", 32'(oData), 32'(expo(16'hABCD)));

    // Drain: read with nothing full.
    rd_done();
    check("t5_rd_ready", 32'(oRdReady), 32'd0);
    check("t5_wr_ready", 32'(oWrReady), 32'd1);
    rd(4'd1);
    check("t5_norm_vld",  32'(oRdValid), 32'd0);
    check("t5_norm_hold", 32'(oData),    32'(expo(16'hABCD)));

    // Out-of-range read returns zero with valid.
    wr_done();
    check("t5_rd_ready2", 32'(oRdReady), 32'd1);
    rd(ADDR_W'(DEPTH));
    check("t5_oor_data", 32'(oData),    32'd0);
    check("t5_oor_vld",  32'(oRdValid), 32'd1);
    rd(4'd0);
    check("t5_pre_rst", 32'(oData), 32'(expo(16'h1234)));

    // Reset while a read is in flight: outputs clear immediately.
    iRdEn = 1'b1; iRdAddr = 4'd0;
    tick();
    iRsn = 1'b0;
    #1;
    check("rst_mid_data",  32'(oData),    32'd0);
    check("rst_mid_vld",   32'(oRdValid), 32'd0);
    check("rst_mid_drop",  32'(oDropCnt), 32'd0);
    check("rst_mid_rdrdy", 32'(oRdReady), 32'd0);
    iRdEn = 1'b0;
    tick();
    iRsn = 1'b1;
    tick();

    // Out-of-range write is discarded but not counted; partial frame stays empty.
    wr(ADDR_W'(DEPTH), 16'h5555);
    check("oor_wr_nodrop", 32'(oDropCnt), 32'd0);
    wr(4'd0, 16'h5555);
    check("partial_rd_rdy", 32'(oRdReady), 32'd0);
    check("partial_wr_rdy", 32'(oWrReady), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
